// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry add/subtract unit.
// The WIDTH-bit ripple chain is cut into STAGES segments of CW bits, and each
// pipeline level resolves one segment. Entry register p[0] latches the prepared
// operands. Level p[k] holds the result of segments 0..k-1 together with the
// carry into segment k. The output register resolves the last segment.
// A result appears STAGES edges after its operands are accepted.
module pipelined_rca #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  // One CW-bit ripple segment: returns {carry_out, segment_sum}.
  function automatic logic [CW:0] add_seg(input logic [CW-1:0] a,
                                          input logic [CW-1:0] b,
                                          input logic          c);
    add_seg = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, c};
  endfunction

  // Per-level skew registers. The operands travel whole. Bits below the
  // segment a level works on are no longer read, so synthesis trims them.
  logic             v_r [STAGES];
  logic [WIDTH-1:0] a_r [STAGES];
  logic [WIDTH-1:0] b_r [STAGES];
  logic [WIDTH-1:0] r_r [STAGES];
  logic             c_r [STAGES];

  logic [CW:0]      seg_s [STAGES];
  logic [WIDTH-1:0] rn_s  [STAGES];
  logic             ovf_s;
  logic             advance_s;

  // The whole pipe moves only when the output slot is empty or being drained.
  assign advance_s = ~out_valid | out_ready;
  assign in_ready  = advance_s;

  // Each level resolves exactly one segment. No carry crosses two segments combinationally.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      seg_s[k] = add_seg(a_r[k][k*CW +: CW], b_r[k][k*CW +: CW], c_r[k]);
      rn_s[k]  = r_r[k];
      rn_s[k][k*CW +: CW] = seg_s[k][CW-1:0];
    end
    if (a_r[STAGES-1][WIDTH-1] == b_r[STAGES-1][WIDTH-1]) begin
      ovf_s = (rn_s[STAGES-1][WIDTH-1] != a_r[STAGES-1][WIDTH-1]);
    end else begin
      ovf_s = 1'b0;
    end
  end

  // Pipeline advance: operand capture, segment hand-off and output retire, all on one enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k] <= 1'b0;
        a_r[k] <= {WIDTH{1'b0}};
        b_r[k] <= {WIDTH{1'b0}};
        r_r[k] <= {WIDTH{1'b0}};
        c_r[k] <= 1'b0;
      end
      out_valid <= 1'b0;
      sum       <= {WIDTH{1'b0}};
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (advance_s) begin
      // Subtraction is A + ~B + 1. The cin input only matters in add mode.
      v_r[0] <= in_valid;
      a_r[0] <= in0;
      b_r[0] <= sub ? ~in1 : in1;
      c_r[0] <= sub | cin;
      r_r[0] <= {WIDTH{1'b0}};
      for (int k = 1; k < STAGES; k++) begin
        v_r[k] <= v_r[k-1];
        a_r[k] <= a_r[k-1];
        b_r[k] <= b_r[k-1];
        r_r[k] <= rn_s[k-1];
        c_r[k] <= seg_s[k-1][CW];
      end
      out_valid <= v_r[STAGES-1];
      // Bubbles leave the last result on the outputs untouched.
      if (v_r[STAGES-1]) begin
        sum  <= rn_s[STAGES-1];
        cout <= seg_s[STAGES-1][CW];
        ovf  <= ovf_s;
      end
    end
  end

endmodule
